// File: rtl/jtbubl_sndcomm_pkg.sv
// Shared constants and types for the main/sound mailbox: register map, status bit
// positions, reset-FSM states and the default sound-reset hold time.
package jtbubl_sndcomm_pkg;

  localparam logic [1:0] SC_DATA = 2'd0;
  localparam logic [1:0] SC_STAT = 2'd1;
  localparam logic [1:0] SC_RST  = 2'd2;

  localparam int ST_PEND  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_IRQEN = 3;

  localparam int SC_RST_HOLD_DEF = 16;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } sc_state_e;

endpackage

// File: rtl/jtbubl_sndcomm_if.sv
// Main CPU register window plus the sound-side command/reply/reset wires.
interface jtbubl_sndcomm_if;
  logic       cs;
  logic [1:0] addr;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_n;
  logic [7:0] snd_latch;
  logic       snd_stb;
  logic [7:0] main_latch;
  logic       main_flag;
  logic       snd_rstn;

  modport slave (
    input  cs, addr, rd_n, wr_n, din, main_latch, main_flag,
    output dout, irq_n, snd_latch, snd_stb, snd_rstn
  );

  modport master (
    output cs, addr, rd_n, wr_n, din, main_latch, main_flag,
    input  dout, irq_n, snd_latch, snd_stb, snd_rstn
  );
endinterface

// File: rtl/jtbubl_sndcomm_fifo.sv
// Reply FIFO (2^AW bytes) with flush and simultaneous push/pop; compiled only when
// JTBUBL_SNDCOMM_FIFO_EN is defined. Output holds the last popped byte while empty.
`ifdef JTBUBL_SNDCOMM_FIFO_EN
module jtbubl_sndcomm_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       full_o,
  output logic       empty_o
);
  logic [AW:0] wp_q, rp_q;
  logic [7:0]  mem_q [0:(1<<AW)-1];
  logic [7:0]  last_q;
  logic        push_ok, pop_ok;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push_ok = push_i & (~full_o | pop_i) & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign dat_o   = empty_o ? last_q : mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      last_q <= '0;
    end else if (flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok) begin
        rp_q   <= rp_q + 1'b1;
        last_q <= mem_q[rp_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= dat_i;
  end
endmodule
`endif

// File: rtl/jtbubl_sndcomm.sv
// Main-CPU side of the main/sound mailbox: command latch, reply buffer, sound CPU reset.
// JTBUBL_SNDCOMM_FIFO_EN selects a 2^FIFO_AW reply FIFO; default is a single reply register.
module jtbubl_sndcomm
  import jtbubl_sndcomm_pkg::*;
#(
  parameter int RST_HOLD = SC_RST_HOLD_DEF,
  parameter int FIFO_AW  = 2
) (
  input logic clk,
  input logic rst,
  jtbubl_sndcomm_if.slave sc_if
);
  localparam int CW = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RST_HOLD - 1);

  logic       wr_act, rd_act, wr_q, rd_q, flag_q;
  logic       wr_start, rd_start, rd_end;
  logic [1:0] rd_addr_q;
  logic       push, pop, flush, pending, full;
  logic [7:0] head, stat, dout_q, latch_q;
  logic       stb_q, ovr_q, irq_en_q, req_q, snd_rstn;
  logic [CW-1:0] cnt_q, cnt_d;
  sc_state_e  state_q, state_d;

  // Strobes may be held for many cycles; only the first cycle of an access acts.
  assign wr_act   = sc_if.cs & ~sc_if.wr_n;
  assign rd_act   = sc_if.cs & ~sc_if.rd_n;
  assign wr_start = wr_act & ~wr_q;
  assign rd_start = rd_act & ~rd_q;
  assign rd_end   = rd_q & ~rd_act;

  assign push  = sc_if.main_flag & ~flag_q;
  assign pop   = rd_end & (rd_addr_q == SC_DATA) & pending;
  assign flush = wr_start & (sc_if.addr == SC_RST) & sc_if.din[0];

`ifdef JTBUBL_SNDCOMM_FIFO_EN
  logic empty;
  jtbubl_sndcomm_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .dat_i(sc_if.main_latch), .dat_o(head), .full_o(full), .empty_o(empty)
  );
  assign pending = ~empty;
`else
  logic       pend_q;
  logic [7:0] rdat_q;
  logic       unused_fifo_aw;
  // A push always lands, overwriting any unread byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      rdat_q <= '0;
    end else if (flush) begin
      pend_q <= 1'b0;
    end else if (push) begin
      pend_q <= 1'b1;
      rdat_q <= sc_if.main_latch;
    end else if (pop) begin
      pend_q <= 1'b0;
    end
  end
  assign pending        = pend_q;
  assign full           = pend_q;
  assign head           = rdat_q;
  assign unused_fifo_aw = (FIFO_AW > 0);
`endif

  always_comb begin
    stat           = '0;
    stat[ST_PEND]  = pending;
    stat[ST_FULL]  = full;
    stat[ST_OVR]   = ovr_q;
    stat[ST_IRQEN] = irq_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      flag_q    <= 1'b0;
      rd_addr_q <= '0;
      dout_q    <= 8'hff;
      latch_q   <= '0;
      stb_q     <= 1'b0;
      ovr_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      wr_q   <= wr_act;
      rd_q   <= rd_act;
      flag_q <= sc_if.main_flag;
      stb_q  <= wr_start & (sc_if.addr == SC_DATA);
      if (wr_start & (sc_if.addr == SC_DATA)) latch_q  <= sc_if.din;
      if (wr_start & (sc_if.addr == SC_STAT)) irq_en_q <= sc_if.din[1];
      if (wr_start & (sc_if.addr == SC_RST))  req_q    <= sc_if.din[0];
      if (flush)                              ovr_q <= 1'b0;
      else if (push & full & ~pop)            ovr_q <= 1'b1;
      else if (wr_start & (sc_if.addr == SC_STAT) & sc_if.din[0]) ovr_q <= 1'b0;
      if (rd_start) begin
        rd_addr_q <= sc_if.addr;
        case (sc_if.addr)
          SC_DATA: dout_q <= head;
          SC_STAT: dout_q <= stat;
          SC_RST:  dout_q <= {7'b0, ~snd_rstn};
          default: dout_q <= 8'hff;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= CNT_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every reset request restarts the hold time, even if already holding.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (flush)                     cnt_d   = CNT_LOAD;
        else if (cnt_q != '0)          cnt_d   = cnt_q - 1'b1;
        else if (!req_q)               state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    snd_rstn = 1'b0;
    if (state_q == RUN) snd_rstn = 1'b1;
  end

  assign sc_if.dout      = dout_q;
  assign sc_if.irq_n     = ~(pending & irq_en_q);
  assign sc_if.snd_latch = latch_q;
  assign sc_if.snd_stb   = stb_q;
  assign sc_if.snd_rstn  = snd_rstn;
endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Directed bench for jtbubl_sndcomm: register window, reply buffer, overrun and reset hold.
// Expectations follow the active build (JTBUBL_SNDCOMM_FIFO_EN on or off).
module tb_jtbubl_sndcomm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  int   stb_cnt = 0;

`ifdef JTBUBL_SNDCOMM_FIFO_EN
  localparam logic [7:0] ST_ONE = 8'h01;
`else
  localparam logic [7:0] ST_ONE = 8'h03;
`endif

  jtbubl_sndcomm_if sc();
  jtbubl_sndcomm #(.RST_HOLD(16), .FIFO_AW(2)) dut (.clk(clk), .rst(rst), .sc_if(sc));

  always #5 clk = ~clk;
  always @(negedge clk) if (sc.snd_stb === 1'b1) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d, input int len);
    @(negedge clk);
    sc.cs = 1'b1; sc.addr = a; sc.din = d; sc.wr_n = 1'b0;
    repeat (len) @(negedge clk);
    sc.cs = 1'b0; sc.wr_n = 1'b1;
  endtask

  task automatic cpu_rd(input logic [1:0] a, input int len, output logic [7:0] d);
    @(negedge clk);
    sc.cs = 1'b1; sc.addr = a; sc.rd_n = 1'b0;
    repeat (len) @(negedge clk);
    d = sc.dout;
    sc.cs = 1'b0; sc.rd_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] b, input int len);
    @(negedge clk);
    sc.main_latch = b; sc.main_flag = 1'b1;
    repeat (len) @(negedge clk);
    sc.main_flag = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (sc.snd_rstn === 1'b1) break;
      @(negedge clk);
    end
    chk(tag, sc.snd_rstn, 1);
  endtask

  initial begin
    logic [7:0] d;
    int low, s0;
    sc.cs = 1'b0; sc.addr = 2'd0; sc.rd_n = 1'b1; sc.wr_n = 1'b1;
    sc.din = 8'h00; sc.main_latch = 8'h00; sc.main_flag = 1'b0;

    // power-up
    repeat (3) @(negedge clk);
    chk("rst_dout", sc.dout, 8'hff);
    chk("rst_irq_n", sc.irq_n, 1);
    chk("rst_latch", sc.snd_latch, 8'h00);
    chk("rst_stb", sc.snd_stb, 0);
    chk("rst_rstn", sc.snd_rstn, 0);
    rst = 1'b0;
    low = 0;
    for (int k = 0; k < 100; k++) begin
      if (sc.snd_rstn === 1'b1) break;
      low++;
      @(negedge clk);
    end
    chk("pwrup_hold", low, 16);
    chk("pwrup_dout", sc.dout, 8'hff);
    chk("pwrup_irq_n", sc.irq_n, 1);

    // command write with a long strobe
    s0 = stb_cnt;
    @(negedge clk);
    sc.cs = 1'b1; sc.addr = 2'd0; sc.din = 8'h5a; sc.wr_n = 1'b0;
    @(negedge clk);
    chk("stb_n1", sc.snd_stb, 1);
    chk("latch_5a", sc.snd_latch, 8'h5a);
    @(negedge clk);
    chk("stb_n2", sc.snd_stb, 0);
    repeat (4) @(negedge clk);
    sc.cs = 1'b0; sc.wr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("stb_count", stb_cnt - s0, 1);
    cpu_wr(2'd3, 8'h77, 1);
    @(negedge clk);
    chk("addr3_wr_ign", sc.snd_latch, 8'h5a);
    chk("addr3_stb", stb_cnt - s0, 1);
    cpu_rd(2'd3, 2, d);
    chk("addr3_rd", d, 8'hff);
    cpu_rd(2'd2, 2, d);
    chk("rst_rd_run", d, 8'h00);

    // reply with IRQ enabled
    cpu_wr(2'd1, 8'h02, 1);
    @(negedge clk);
    sc.main_latch = 8'h21; sc.main_flag = 1'b1;
    @(negedge clk);
    chk("irq_n_n1", sc.irq_n, 0);
    repeat (2) @(negedge clk);
    sc.main_flag = 1'b0;
    cpu_rd(2'd1, 2, d);
    chk("stat_pend", d, 8'h08 | ST_ONE);
    @(negedge clk);
    sc.cs = 1'b1; sc.addr = 2'd0; sc.rd_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("irq_mid_read", sc.irq_n, 0);
    chk("rd_21", sc.dout, 8'h21);
    sc.cs = 1'b0; sc.rd_n = 1'b1;
    @(negedge clk);
    chk("irq_n_popped", sc.irq_n, 1);
    cpu_rd(2'd1, 2, d);
    chk("stat_empty", d, 8'h08);
    cpu_rd(2'd0, 2, d);
    chk("rd_empty_last", d, 8'h21);
    cpu_rd(2'd1, 2, d);
    chk("stat_after_empty_pop", d, 8'h08);

    // reset request mid-run with a pending reply
    push(8'h33, 1);
    chk("irq_before_req", sc.irq_n, 0);
    @(negedge clk);
    sc.cs = 1'b1; sc.addr = 2'd2; sc.din = 8'h01; sc.wr_n = 1'b0;
    low = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sc.snd_rstn === 1'b1) break;
      low++;
      if (k == 0) begin
        sc.cs = 1'b0; sc.wr_n = 1'b1;
        chk("req_flush_irq", sc.irq_n, 1);
      end else if (k == 2) begin
        sc.cs = 1'b1; sc.addr = 2'd2; sc.din = 8'h00; sc.wr_n = 1'b0;
      end else if (k == 3) begin
        sc.cs = 1'b0; sc.wr_n = 1'b1;
      end
    end
    chk("req_hold", low, 16);
    cpu_rd(2'd1, 2, d);
    chk("req_stat", d, 8'h08);

    // asynchronous reset mid-operation
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_latch", sc.snd_latch, 8'h00);
    chk("arst_dout", sc.dout, 8'hff);
    chk("arst_rstn", sc.snd_rstn, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_run("arst_release");

    // overrun (irq_en is 0 after reset)
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    cpu_rd(2'd1, 2, d);
    chk("ovr_stat", d, 8'h07);
    for (int i = 1; i <= 4; i++) begin
      cpu_rd(2'd0, 2, d);
      chk("ovr_rd", d, 32'(i));
    end
`else
    push(8'haa, 1);
    push(8'hbb, 2);
    cpu_rd(2'd1, 2, d);
    chk("ovr_stat", d, 8'h07);
    cpu_rd(2'd0, 2, d);
    chk("ovr_rd", d, 8'hbb);
`endif
    cpu_rd(2'd1, 2, d);
    chk("ovr_stat_drained", d, 8'h04);
    cpu_wr(2'd1, 8'h01, 1);
    cpu_rd(2'd1, 2, d);
    chk("ovr_clear", d, 8'h00);

    // push and pop in the same cycle while full
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i), 1);
`else
    push(8'hcc, 1);
`endif
    @(negedge clk);
    sc.cs = 1'b1; sc.addr = 2'd0; sc.rd_n = 1'b0;
    repeat (2) @(negedge clk);
    d = sc.dout;
    sc.cs = 1'b0; sc.rd_n = 1'b1;
    sc.main_latch = 8'hdd; sc.main_flag = 1'b1;
    @(negedge clk);
    sc.main_flag = 1'b0;
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    chk("pp_head", d, 8'h11);
`else
    chk("pp_head", d, 8'hcc);
`endif
    cpu_rd(2'd1, 2, d);
    chk("pp_stat", d, 8'h03);
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    for (int i = 0; i < 3; i++) begin
      cpu_rd(2'd0, 2, d);
      chk("pp_rd", d, 32'h12 + 32'(i));
    end
`endif
    cpu_rd(2'd0, 2, d);
    chk("pp_rd_new", d, 8'hdd);
    cpu_rd(2'd1, 2, d);
    chk("pp_stat_end", d, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
